dff_chain_loader: RTL and testbench

Sequencing controller for a chain of D flip-flop stages. It accepts a parallel word on a start strobe and shifts it serially into a WIDTH-stage flop chain, one bit per clock. When the last bit lands it flags completion, then exposes the chain contents and their complements in parallel. It is the control layer the single D flip-flop datapath needs to act as a loadable register, with abort and clear support.

---
 rtl/dff_chain_pkg.sv | 18 +
 rtl/dff_stage.sv | 28 ++
 rtl/dff_chain_loader.sv | 120 ++++++++++++
 tb/tb_dff_chain_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dff_chain_pkg.sv
// Shared types and sizing helpers for the serial flop-chain loader.
// Pure declarations; no logic, no latency, no flow control.
package dff_chain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } loader_state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Width of the bit index counter; never narrower than one bit.
   function automatic int cnt_w(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/dff_stage.sv
// One chain flop: sync reset and clear beat enable; one-cycle latency.
// No backpressure; holds its value whenever en and clr are low.
module dff_stage (
   input  logic clk_signal,
   input  logic rst_signal,
   input  logic en,
   input  logic clr,
   input  logic d,
   output logic q,
   output logic q_inv
);

   logic bit_q;

   always_ff @(posedge clk_signal) begin
      if (rst_signal) begin
         bit_q <= 1'b0;
      end else if (clr) begin
         bit_q <= 1'b0;
      end else if (en) begin
         bit_q <= d;
      end
   end

   assign q     = bit_q;
   assign q_inv = ~bit_q;

endmodule

// File: rtl/dff_chain_loader.sv
// Loads a parallel word serially into a WIDTH-stage flop chain, one bit per clock.
// Load period WIDTH+2 cycles; start is only taken while ready, abort/clear cancel.
module dff_chain_loader
   import dff_chain_pkg::*;
#(
   parameter int  WIDTH     = DEFAULT_WIDTH,
   parameter bit  LSB_FIRST = 1'b1,
   localparam int CW        = cnt_w(WIDTH)
) (
   input  logic             clk_signal,
   input  logic             rst_signal,
   input  logic             start,
   input  logic [WIDTH-1:0] load_data,
   input  logic             abort,
   input  logic             clear,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             ser_bit,
   output logic [CW-1:0]    bit_cnt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_inv
);

   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   loader_state_t    state_q, state_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    sel;
   logic             shift_en;
   logic             chain_clr;
   logic [WIDTH-1:0] chain_d;

   always_ff @(posedge clk_signal) begin
      if (rst_signal) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (!clear && start) begin
               state_d  = SHIFT;
               shadow_d = load_data;
               cnt_d    = '0;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Every output decodes registered state only, so no input reaches an output.
   always_comb begin
      ready     = (state_q == IDLE);
      busy      = (state_q == SHIFT);
      done      = (state_q == DONE);
      sel       = LSB_FIRST ? cnt_q : (LAST_CNT - cnt_q);
      ser_bit   = busy ? shadow_q[sel] : 1'b0;
      shift_en  = busy && !abort;
      chain_clr = (ready && clear) || (busy && abort);
   end

   assign bit_cnt = cnt_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      // LSB-first feeds the top stage and shifts down; MSB-first the reverse.
      if (LSB_FIRST) begin : g_lsb
         if (i == WIDTH - 1) begin : g_in
            assign chain_d[i] = ser_bit;
         end else begin : g_mid
            assign chain_d[i] = q[i+1];
         end
      end else begin : g_msb
         if (i == 0) begin : g_in
            assign chain_d[i] = ser_bit;
         end else begin : g_mid
            assign chain_d[i] = q[i-1];
         end
      end

      dff_stage u_stage (
         .clk_signal (clk_signal),
         .rst_signal (rst_signal),
         .en         (shift_en),
         .clr        (chain_clr),
         .d          (chain_d[i]),
         .q          (q[i]),
         .q_inv      (q_inv[i])
      );
   end

endmodule

// File: tb/tb_dff_chain_loader.sv
// Drives an LSB-first and an MSB-first loader with identical stimulus and
// compares both against an arithmetic model of the chain contents.
module tb_dff_chain_loader;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] load_data = '0;
   logic         abort = 1'b0;
   logic         clear = 1'b0;

   logic         ready_l, busy_l, done_l, ser_l;
   logic [2:0]   cnt_l;
   logic [W-1:0] q_l, qi_l;
   logic         ready_m, busy_m, done_m, ser_m;
   logic [2:0]   cnt_m;
   logic [W-1:0] q_m, qi_m;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q = '0;

   always #5 clk = ~clk;

   dff_chain_loader #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
      .clk_signal (clk), .rst_signal (rst), .start (start), .load_data (load_data),
      .abort (abort), .clear (clear), .ready (ready_l), .busy (busy_l), .done (done_l),
      .ser_bit (ser_l), .bit_cnt (cnt_l), .q (q_l), .q_inv (qi_l)
   );

   dff_chain_loader #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
      .clk_signal (clk), .rst_signal (rst), .start (start), .load_data (load_data),
      .abort (abort), .clear (clear), .ready (ready_m), .busy (busy_m), .done (done_m),
      .ser_bit (ser_m), .bit_cnt (cnt_m), .q (q_m), .q_inv (qi_m)
   );

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Chain contents after j shifts: old bits slide away from the input end
   // while the first j bits of the word arrive behind them.
   function automatic logic [W-1:0] model_q(input bit lsb, input logic [W-1:0] old,
                                            input logic [W-1:0] data, input int j);
      logic [W-1:0] r;
      if (lsb) r = (old >> j) | (data << (W - j));
      else     r = (old << j) | (data >> (W - j));
      return r;
   endfunction

   task automatic check_idle(input string tag, input logic [W-1:0] eq);
      n_cmp++;
      if ({ready_l, ready_m, busy_l, busy_m, done_l, done_m, ser_l, ser_m} !== 8'b1100_0000) begin
         n_err++;
         $display("FAIL %s flags: got rdy=%b%b busy=%b%b done=%b%b ser=%b%b want rdy=11 busy=00 done=00 ser=00",
                  tag, ready_l, ready_m, busy_l, busy_m, done_l, done_m, ser_l, ser_m);
      end
      n_cmp++;
      if ({q_l, q_m, qi_l, qi_m, cnt_l, cnt_m} !== {eq, eq, ~eq, ~eq, 6'd0}) begin
         n_err++;
         $display("FAIL %s data: got q=%h/%h q_inv=%h/%h cnt=%0d/%0d want q=%h q_inv=%h cnt=0",
                  tag, q_l, q_m, qi_l, qi_m, cnt_l, cnt_m, eq, ~eq);
      end
   endtask

   // One load; cut_at >= 0 cancels it (abort or reset) before shift number cut_at.
   task automatic run_load(input logic [W-1:0] data, input int cut_at, input bit use_rst,
                           input bit noisy);
      start = 1'b1; load_data = data; clear = 1'b0; abort = 1'b0;
      cyc();
      start = 1'b0;
      for (int j = 0; j < W; j++) begin
         if (j == cut_at) begin
            if (use_rst) rst = 1'b1; else abort = 1'b1;
            cyc();
            rst = 1'b0; abort = 1'b0; start = 1'b0; clear = 1'b0;
            exp_q = '0;
            check_idle(use_rst ? "reset_cut" : "abort_cut", exp_q);
            for (int n = 0; n < W + 2; n++) begin
               n_cmp++;
               if ({done_l, done_m, ready_l, ready_m} !== 4'b0011) begin
                  n_err++;
                  $display("FAIL after_cut n=%0d: got done=%b%b rdy=%b%b want done=00 rdy=11",
                           n, done_l, done_m, ready_l, ready_m);
               end
               cyc();
            end
            return;
         end
         n_cmp++;
         if ({busy_l, busy_m, ready_l, ready_m, done_l, done_m, cnt_l, cnt_m} !==
             {6'b110000, 3'(j), 3'(j)}) begin
            n_err++;
            $display("FAIL shift j=%0d: got busy=%b%b rdy=%b%b done=%b%b cnt=%0d/%0d want busy=11 rdy=00 done=00 cnt=%0d",
                     j, busy_l, busy_m, ready_l, ready_m, done_l, done_m, cnt_l, cnt_m, j);
         end
         n_cmp++;
         if ({ser_l, ser_m} !== {data[j], data[W-1-j]}) begin
            n_err++;
            $display("FAIL ser_bit j=%0d: got %b/%b want %b/%b", j, ser_l, ser_m, data[j], data[W-1-j]);
         end
         if (noisy) begin
            start = 1'($urandom); clear = 1'($urandom); load_data = W'($urandom);
         end
         cyc();
         n_cmp++;
         if ({q_l, q_m} !== {model_q(1'b1, exp_q, data, j + 1), model_q(1'b0, exp_q, data, j + 1)}) begin
            n_err++;
            $display("FAIL chain j=%0d: got %h/%h want %h/%h", j + 1, q_l, q_m,
                     model_q(1'b1, exp_q, data, j + 1), model_q(1'b0, exp_q, data, j + 1));
         end
      end
      n_cmp++;
      if ({done_l, done_m, busy_l, busy_m, ready_l, ready_m, q_l, q_m, qi_l, qi_m} !==
          {6'b110000, data, data, ~data, ~data}) begin
         n_err++;
         $display("FAIL done_state: got done=%b%b busy=%b%b rdy=%b%b q=%h/%h q_inv=%h/%h want done=11 q=%h q_inv=%h",
                  done_l, done_m, busy_l, busy_m, ready_l, ready_m, q_l, q_m, qi_l, qi_m, data, ~data);
      end
      exp_q = data;
      cyc();
      start = 1'b0; clear = 1'b0;
      check_idle("post_done", exp_q);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      exp_q = '0;
      check_idle("reset", exp_q);
      cyc();
      check_idle("reset_hold", exp_q);
   endtask

   task automatic test_basic_load();
      run_load(8'hA5, -1, 1'b0, 1'b0);
      run_load(8'h3C, -1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      start = 1'b1; load_data = 8'hFF;
      cyc();
      load_data = 8'h81;
      for (int n = 1; n <= W + 2; n++) begin
         cyc();
         n_cmp++;
         if ({busy_l, busy_m, done_l, done_m} !==
             {{2{(n < W) || (n == W + 2)}}, {2{n == W}}}) begin
            n_err++;
            $display("FAIL b2b n=%0d: got busy=%b%b done=%b%b", n, busy_l, busy_m, done_l, done_m);
         end
      end
      n_cmp++;
      if ({cnt_l, cnt_m, q_l, q_m} !== {6'd0, 8'hFF, 8'hFF}) begin
         n_err++;
         $display("FAIL b2b_accept: got cnt=%0d/%0d q=%h/%h want cnt=0 q=ff", cnt_l, cnt_m, q_l, q_m);
      end
      start = 1'b0;
      for (int n = 1; n <= W; n++) begin
         cyc();
         n_cmp++;
         if ({done_l, done_m} !== {2{n == W}}) begin
            n_err++;
            $display("FAIL b2b_second n=%0d: got done=%b%b", n, done_l, done_m);
         end
      end
      n_cmp++;
      if ({q_l, q_m, qi_l, qi_m} !== {8'h81, 8'h81, 8'h7E, 8'h7E}) begin
         n_err++;
         $display("FAIL b2b_q: got q=%h/%h q_inv=%h/%h want q=81 q_inv=7e", q_l, q_m, qi_l, qi_m);
      end
      exp_q = 8'h81;
      cyc();
      check_idle("b2b_end", exp_q);
   endtask

   task automatic test_abort_reset();
      run_load(8'hF0, 4, 1'b0, 1'b0);
      run_load(8'hF0, 4, 1'b1, 1'b0);
      run_load(8'h6B, W - 1, 1'b0, 1'b0);
   endtask

   task automatic test_clear_priority();
      run_load(8'h5A, -1, 1'b0, 1'b0);
      check_idle("hold_5a", exp_q);
      start = 1'b1; clear = 1'b1; load_data = 8'hC3;
      cyc();
      start = 1'b0; clear = 1'b0;
      exp_q = '0;
      check_idle("clear_start", exp_q);
      for (int n = 0; n < 4; n++) begin
         cyc();
         check_idle("clear_idle", exp_q);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 16; it++) begin
         int cut;
         cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
         run_load(W'($urandom), cut, 1'($urandom), 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            clear = 1'b1;
            cyc();
            clear = 1'b0;
            exp_q = '0;
            check_idle("rand_clear", exp_q);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic_load();
      test_back_to_back();
      test_abort_reset();
      test_clear_priority();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
